// File: rtl/rx_word_buffer.sv
// ---------------------------------------------------------------------------
// rx_word_buffer
//
// Receives 10-bit words from the channel receive stage along with a
// parity-good flag. Bit 9 of each word is the parity bit and is discarded.
// Good 9-bit payloads are queued in a small first-word-fall-through FIFO.
// Parity errors are counted. A two-state link FSM stops accepting data after
// a run of bad words, and starts again after a run of good words.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_stb     in   1      in_data/in_valid carry a new word this cycle
//   in_data    in   10     received word; [9] parity bit, [8:0] payload
//   in_valid   in   1      parity check passed for in_data
//   clr_stats  in   1      synchronous clear of err_count and overflow
//   out_data   out  9      FIFO head payload (don't-care while out_valid=0)
//   out_valid  out  1      FIFO non-empty
//   out_ready  in   1      consumer accepts the head this cycle
//   level      out  AW+1   FIFO occupancy, 0..DEPTH
//   err_count  out  CNT_W  saturating parity-error count
//   overflow   out  1      sticky: a good word was dropped on a full FIFO
//   link_up    out  1      link FSM is in LINK_UP
//
// Output handshake: the head word transfers on every rising clk edge where
// out_valid and out_ready are both 1. out_valid never depends on out_ready.
// While out_valid=1, out_data stays stable until the word transfers.
// out_ready may change freely while out_valid=0.
// ---------------------------------------------------------------------------
module rx_word_buffer #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int CNT_W      = 8,
    parameter int BAD_LIMIT  = 4,
    parameter int GOOD_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_stb,
    input  logic [9:0]       in_data,
    input  logic             in_valid,
    input  logic             clr_stats,
    output logic [8:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] err_count,
    output logic             overflow,
    output logic             link_up
);

    // The run counters need to reach the larger of the two limits.
    localparam int RUN_MAX = (BAD_LIMIT > GOOD_LIMIT) ? BAD_LIMIT : GOOD_LIMIT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0] BAD_LIM    = RUN_W'(BAD_LIMIT);
    localparam logic [RUN_W-1:0] GOOD_LIM   = RUN_W'(GOOD_LIMIT);
    localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {
        LINK_UP_S   = 1'b0,
        LINK_DOWN_S = 1'b1
    } link_state_t;

    // ------------------------------------------------------------------
    // Strobe classification
    // ------------------------------------------------------------------
    logic good;
    logic bad;

    assign good = in_stb & in_valid;
    assign bad  = in_stb & ~in_valid;

    // The parity bit has already been checked upstream, so this block only
    // carries it through the port and does not use it.
    logic unused_parity;
    assign unused_parity = in_data[9];

    // ------------------------------------------------------------------
    // Link FSM: state register plus run counters
    // ------------------------------------------------------------------
    link_state_t      state, state_nxt;
    logic [RUN_W-1:0] bad_run, bad_run_nxt;
    logic [RUN_W-1:0] good_run, good_run_nxt;
    logic [RUN_W-1:0] bad_run_inc;
    logic [RUN_W-1:0] good_run_inc;

    // Saturating increments. The counters stop at their own limit.
    assign bad_run_inc  = (bad_run  >= BAD_LIM)  ? BAD_LIM  : bad_run  + 1'b1;
    assign good_run_inc = (good_run >= GOOD_LIM) ? GOOD_LIM : good_run + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LINK_UP_S;
            bad_run  <= '0;
            good_run <= '0;
        end else begin
            state    <= state_nxt;
            bad_run  <= bad_run_nxt;
            good_run <= good_run_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bad_run_nxt  = bad_run;
        good_run_nxt = good_run;
        link_up      = 1'b0;

        unique case (state)
            LINK_UP_S: begin
                link_up = 1'b1;
                if (bad) begin
                    bad_run_nxt = bad_run_inc;
                    // The state changes on the same edge that the run
                    // reaches the limit.
                    if (bad_run_inc == BAD_LIM) begin
                        state_nxt    = LINK_DOWN_S;
                        good_run_nxt = '0;
                    end
                end else if (good) begin
                    bad_run_nxt = '0;
                end
            end

            LINK_DOWN_S: begin
                if (good) begin
                    good_run_nxt = good_run_inc;
                    // The word that completes recovery is still dropped,
                    // because the push logic sees link_up=0 this cycle.
                    if (good_run_inc == GOOD_LIM) begin
                        state_nxt   = LINK_UP_S;
                        bad_run_nxt = '0;
                    end
                end else if (bad) begin
                    good_run_nxt = '0;
                end
            end

            default: begin
                state_nxt = LINK_UP_S;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic          pop;
    logic          push;
    logic          full;
    logic          drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    mem [DEPTH];

    assign out_valid = (level != '0);
    assign full      = (level == FULL_LEVEL);
    assign pop       = out_valid & out_ready;

    // A full FIFO still accepts a word when the head leaves in the same
    // cycle.
    assign push = good & link_up & (~full | pop);
    assign drop = good & link_up & full & ~pop;

    // The pointers wrap naturally because DEPTH is 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage has no reset; out_data is only meaningful while out_valid=1.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data[8:0];
        end
    end

    // Fall-through: the head is read combinationally from the array.
    assign out_data = mem[rd_ptr];

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else if (clr_stats) begin
            // A clear wins over any error or overflow event in the same cycle.
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (bad && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
